// File: rtl/axis_vae_frame_builder.sv
// axis_vae_frame_builder
// Holds one set of VAE weight/bias words loaded over a config AXI-Stream.
// For every feature vector it emits the full frame the VAE core expects:
// WB_WORDS weight/bias beats, then N_FEAT feature beats (feature in the top
// FEAT_W bits), with tlast on the final beat.
//
// Optional build macro: VAE_FRAME_CNT_EN adds a 16-bit frame_count output
// that counts accepted tlast beats (wrapping).
//
// Handshake rule on every stream: a beat transfers on the rising clock edge
// where tvalid and tready are both 1; a source holding tvalid=1 keeps tdata
// and tlast stable until that edge, and tvalid never depends on tready.
module axis_vae_frame_builder #(
    parameter int WB_WORDS = 27,
    parameter int N_FEAT   = 9,
    parameter int FEAT_W   = 16,
    parameter int DATA_W   = 64
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_cfg_axis_tdata,
    input  logic              s_cfg_axis_tvalid,
    input  logic              s_cfg_axis_tlast,
    output logic              s_cfg_axis_tready,
    input  logic [FEAT_W-1:0] s_feat_axis_tdata,
    input  logic              s_feat_axis_tvalid,
    input  logic              s_feat_axis_tlast,
    output logic              s_feat_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              cfg_loaded,
    output logic              cfg_err,
    output logic              feat_err
`ifdef VAE_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_count
`endif
);

    localparam int CNT_W = $clog2(WB_WORDS + 1);
    localparam int FC_W  = $clog2(N_FEAT + 1);
    localparam logic [CNT_W-1:0] WB_LAST   = CNT_W'(WB_WORDS - 1);
    localparam logic [FC_W-1:0]  FEAT_LAST = FC_W'(N_FEAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY,
        ST_SEND_WB,
        ST_SEND_FEAT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cfg_cnt_q, cfg_cnt_d;
    logic              cfg_drop_q, cfg_drop_d;
    logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;
    logic [FC_W-1:0]   f_cnt_q, f_cnt_d;
    logic              cfg_loaded_q, cfg_loaded_d;
    logic              cfg_err_q, cfg_err_d;
    logic              feat_err_q, feat_err_d;

    logic [DATA_W-1:0] wb_mem_q [WB_WORDS];
    logic              mem_we;
    logic [CNT_W-1:0]  beat_idx;
    logic              cfg_rdy;
    logic              feat_last;

    // Next-state, counters, flags and all stream outputs
    always_comb begin
        state_d            = state_q;
        cfg_cnt_d          = cfg_cnt_q;
        cfg_drop_d         = cfg_drop_q;
        wb_cnt_d           = wb_cnt_q;
        f_cnt_d            = f_cnt_q;
        cfg_loaded_d       = cfg_loaded_q;
        cfg_err_d          = cfg_err_q;
        feat_err_d         = feat_err_q;
        mem_we             = 1'b0;
        s_feat_axis_tready = 1'b0;
        m_axis_tvalid      = 1'b0;
        m_axis_tlast       = 1'b0;
        m_axis_tdata       = '0;
        feat_last          = (f_cnt_q == FEAT_LAST);

        // Config is accepted only between frames; held off while in reset.
        cfg_rdy = aresetn && ((state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                              (state_q == ST_READY));
        s_cfg_axis_tready = cfg_rdy;
        // A beat arriving outside LOAD is the first word of a new set.
        beat_idx = (state_q == ST_LOAD) ? cfg_cnt_q : '0;

        case (state_q)
            ST_IDLE, ST_LOAD, ST_READY: begin
                if (cfg_rdy && s_cfg_axis_tvalid) begin
                    cfg_loaded_d = 1'b0;
                    if ((state_q == ST_LOAD) && cfg_drop_q) begin
                        // Overlong set: discard until its tlast shows up.
                        if (s_cfg_axis_tlast) begin
                            state_d    = ST_IDLE;
                            cfg_drop_d = 1'b0;
                            cfg_cnt_d  = '0;
                        end
                    end else begin
                        mem_we = 1'b1;
                        if (s_cfg_axis_tlast) begin
                            cfg_cnt_d = '0;
                            if (beat_idx == WB_LAST) begin
                                cfg_loaded_d = 1'b1;
                                state_d      = ST_READY;
                            end else begin
                                cfg_err_d = 1'b1;
                                state_d   = ST_IDLE;
                            end
                        end else if (beat_idx == WB_LAST) begin
                            cfg_err_d  = 1'b1;
                            cfg_drop_d = 1'b1;
                            state_d    = ST_LOAD;
                        end else begin
                            cfg_cnt_d = beat_idx + 1'b1;
                            state_d   = ST_LOAD;
                        end
                    end
                end else if ((state_q == ST_READY) && cfg_loaded_q &&
                             s_feat_axis_tvalid) begin
                    state_d  = ST_SEND_WB;
                    wb_cnt_d = '0;
                end
            end

            ST_SEND_WB: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = wb_mem_q[wb_cnt_q];
                if (m_axis_tready) begin
                    if (wb_cnt_q == WB_LAST) begin
                        state_d = ST_SEND_FEAT;
                        f_cnt_d = '0;
                    end else begin
                        wb_cnt_d = wb_cnt_q + 1'b1;
                    end
                end
            end

            ST_SEND_FEAT: begin
                // Zero-latency pass-through; framing follows our own counter.
                m_axis_tdata       = {s_feat_axis_tdata, {(DATA_W-FEAT_W){1'b0}}};
                m_axis_tvalid      = s_feat_axis_tvalid;
                m_axis_tlast       = feat_last;
                s_feat_axis_tready = m_axis_tready;
                if (s_feat_axis_tvalid && m_axis_tready) begin
                    if (s_feat_axis_tlast != feat_last) begin
                        feat_err_d = 1'b1;
                    end
                    if (feat_last) begin
                        state_d = ST_READY;
                    end else begin
                        f_cnt_d = f_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state register with asynchronous reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            cfg_cnt_q    <= '0;
            cfg_drop_q   <= 1'b0;
            wb_cnt_q     <= '0;
            f_cnt_q      <= '0;
            cfg_loaded_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            feat_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_cnt_q    <= cfg_cnt_d;
            cfg_drop_q   <= cfg_drop_d;
            wb_cnt_q     <= wb_cnt_d;
            f_cnt_q      <= f_cnt_d;
            cfg_loaded_q <= cfg_loaded_d;
            cfg_err_q    <= cfg_err_d;
            feat_err_q   <= feat_err_d;
        end
    end

    // Weight/bias storage; contents only trusted while cfg_loaded is set
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            wb_mem_q[beat_idx] <= s_cfg_axis_tdata;
        end
    end

    assign cfg_loaded = cfg_loaded_q;
    assign cfg_err    = cfg_err_q;
    assign feat_err   = feat_err_q;

`ifdef VAE_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    // Count frames whose final beat the core has accepted
    always_comb begin
        frame_count_d = frame_count_q;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // Frame counter register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule
